// File: rtl/timer_ctrl_if.sv
// APB-style slave bus bundle for the timer controller.
// The master drives select, phase, direction, address and write data.
// The slave returns read data, completion and error.
interface timer_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [7:0]        pwdata;
   logic [7:0]        prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/timer_ctrl.sv
// Register-interface controller for the 8-bit timer counter.
// It holds TDR (reload value) and TCR (control bits), and it sequences
// one-cycle load and flag-clear strobes. It also generates the prescaled
// count tick, reads back the count and flags, and drives a level interrupt.
module timer_ctrl #(
   parameter int ADDR_W = 8,
   parameter int PSC_W  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   timer_ctrl_if.slave bus,
   input  logic [7:0] i_tcnt,
   input  logic       i_overflow,
   input  logic       i_underflow,
   output logic [7:0] o_start_counter,
   output logic       o_load,
   output logic       o_up_down,
   output logic       o_enable,
   output logic       o_clk_ena,
   output logic       o_clr_overflow,
   output logic       o_clr_underflow,
   output logic       o_irq
);

   localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(8'h01);
   localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(8'h02);
   localparam logic [ADDR_W-1:0] A_TCNT = ADDR_W'(8'h03);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [7:0]       r_tdr;
   logic [5:0]       r_tcr;        // {up_down, enable, UDIE, OVIE, CKS[1:0]}
   logic             r_load;
   logic             r_clr_ov;
   logic             r_clr_ud;

   logic [7:0]       r_prdata;
   logic             r_pready;
   logic             r_pslverr;

   logic [PSC_W-1:0] r_psc;
   logic [PSC_W-1:0] r_psc_prev;
   logic [PSC_W-1:0] r_rise;
   logic             r_ena_q;

   logic             w_in_wait;
   logic             w_commit;
   logic             w_sel_tdr;
   logic             w_sel_tcr;
   logic             w_sel_tsr;
   logic             w_mapped;
   logic [7:0]       w_rd_mux;
   logic             w_clk_ena;

   assign w_sel_tdr = (bus.paddr == A_TDR);
   assign w_sel_tcr = (bus.paddr == A_TCR);
   assign w_sel_tsr = (bus.paddr == A_TSR);
   assign w_mapped  = w_sel_tdr | w_sel_tcr | w_sel_tsr | (bus.paddr == A_TCNT);

   // The access is resolved in WAIT, so its effects land on the edge entering DONE.
   assign w_in_wait = (r_state == S_WAIT);
   assign w_commit  = w_in_wait & bus.pwrite;

   // Bus FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every sequential block uses non-blocking (<=) so that all flops
      // sample pre-edge values; blocking here would create order-dependent races.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Bus FSM next-state logic: one fixed wait state between access and completion.
   always_comb begin
      // NOTE: assign the default before the case so that every path drives
      // w_next; a missing branch would otherwise infer a latch.
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.psel && !bus.penable) w_next = S_SETUP;
         S_SETUP: begin
            if (!bus.psel)        w_next = S_IDLE;
            else if (bus.penable) w_next = S_WAIT;
         end
         S_WAIT:  w_next = S_DONE;
         S_DONE:  w_next = (bus.psel && !bus.penable) ? S_SETUP : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Read-data selection. Write-only and reserved bits read as 0.
   always_comb begin
      w_rd_mux = 8'h00;
      case (bus.paddr)
         A_TDR:   w_rd_mux = r_tdr;
         A_TCR:   w_rd_mux = {2'b00, r_tcr};
         A_TSR:   w_rd_mux = {6'b0, i_underflow, i_overflow};
         A_TCNT:  w_rd_mux = i_tcnt;
         default: w_rd_mux = 8'h00;
      endcase
   end

   // Register commits and single-cycle strobes. The strobes fire in the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tdr    <= 8'h00;
         r_tcr    <= 6'h00;
         r_load   <= 1'b0;
         r_clr_ov <= 1'b0;
         r_clr_ud <= 1'b0;
      end else begin
         r_load   <= 1'b0;
         r_clr_ov <= 1'b0;
         r_clr_ud <= 1'b0;
         if (w_commit) begin
            if (w_sel_tdr) r_tdr <= bus.pwdata;
            if (w_sel_tcr) begin
               r_tcr  <= bus.pwdata[5:0];
               r_load <= bus.pwdata[7];
            end
            if (w_sel_tsr) begin
               r_clr_ov <= bus.pwdata[0];
               r_clr_ud <= bus.pwdata[1];
            end
         end
      end
   end

   // Registered bus response. It is valid only in the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= 8'h00;
      end else begin
         r_pready  <= w_in_wait;
         r_pslverr <= w_in_wait & ~w_mapped;
         r_prdata  <= (w_in_wait && !bus.pwrite) ? w_rd_mux : 8'h00;
      end
   end

   // Free-running prescaler with a registered rising-edge detect on every bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_psc      <= '0;
         r_psc_prev <= '0;
         r_rise     <= '0;
         r_ena_q    <= 1'b0;
      end else begin
         r_psc      <= r_psc + PSC_W'(1);
         r_psc_prev <= r_psc;
         r_rise     <= r_psc & ~r_psc_prev;
         r_ena_q    <= w_clk_ena;
      end
   end

   // Each counter value has a unique lowest set bit, so the per-bit rise pulses
   // never overlap. A CKS switch can still place a new-bit pulse right after an
   // old-bit pulse. Masking with the previous tick keeps every tick isolated.
   // In steady state the ticks are never back to back, so the mask has no effect.
   assign w_clk_ena = r_rise[r_tcr[1:0]] & ~r_ena_q;

   assign bus.prdata      = r_prdata;
   assign bus.pready      = r_pready;
   assign bus.pslverr     = r_pslverr;

   assign o_start_counter = r_tdr;
   assign o_load          = r_load;
   assign o_up_down       = r_tcr[5];
   assign o_enable        = r_tcr[4];
   assign o_clk_ena       = w_clk_ena;
   assign o_clr_overflow  = r_clr_ov;
   assign o_clr_underflow = r_clr_ud;
   assign o_irq           = (i_overflow & r_tcr[2]) | (i_underflow & r_tcr[3]);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl.
// The bench queues the expected response of each bus transfer when it drives
// the transfer, and compares that response when pready completes the transfer.
// Side-band monitors count the strobes and the prescaler ticks.
module tb_timer_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] tcnt;
   logic       overflow;
   logic       underflow;
   logic [7:0] start_counter;
   logic       load, up_down, enable, clk_ena, clr_overflow, clr_underflow, irq;

   timer_ctrl_if #(.ADDR_W(8)) bus ();

   timer_ctrl #(.ADDR_W(8), .PSC_W(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .i_tcnt          (tcnt),
      .i_overflow      (overflow),
      .i_underflow     (underflow),
      .o_start_counter (start_counter),
      .o_load          (load),
      .o_up_down       (up_down),
      .o_enable        (enable),
      .o_clk_ena       (clk_ena),
      .o_clr_overflow  (clr_overflow),
      .o_clr_underflow (clr_underflow),
      .o_irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       chk_rd;
      string      name;
   } exp_t;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       err;
      logic       chk_rd;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   // Monitors
   int cyc = 0;
   int load_cnt = 0, clrov_cnt = 0, clrud_cnt = 0, both_cnt = 0;
   logic ld_ud = 1'b0, ld_en = 1'b0, ld_rdy = 1'b0, clr_rdy = 1'b1;
   int last_ena = -1000, min_gap = 1000;
   int rdy_run = 0, max_rdy_run = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (load) begin
         load_cnt++;
         ld_ud  = up_down;
         ld_en  = enable;
         ld_rdy = bus.pready;
      end
      if (clr_overflow)  clrov_cnt++;
      if (clr_underflow) clrud_cnt++;
      if (clr_overflow && clr_underflow) both_cnt++;
      if ((clr_overflow || clr_underflow) && !bus.pready) clr_rdy = 1'b0;
      if (clk_ena) begin
         if (cyc - last_ena < min_gap) min_gap = cyc - last_ena;
         last_ena = cyc;
      end
      if (bus.pready) rdy_run++;
      else            rdy_run = 0;
      if (rdy_run > max_rdy_run) max_rdy_run = rdy_run;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else             n_pass++;
   endtask

   function automatic vec_t mkv(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] rdata, input logic err, input logic chk_rd);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err; v.chk_rd = chk_rd;
      return v;
   endfunction

   // A single APB transfer. The expected response is queued first, then popped
   // and compared when pready is seen.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rd, input logic exp_err, input logic chk_rd,
                       input string name);
      exp_t e;
      int   lat;
      bit   got;
      e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd; e.name = name;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
      @(posedge clk); #1;
      bus.penable = 1'b1;
      lat = 0; got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.pready) got = 1;
      end
      if (!got) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
         void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.name, "_lat"}, lat, 2);
         check({e.name, "_err"}, bus.pslverr, e.err);
         if (e.chk_rd) check({e.name, "_rd"}, bus.prdata, e.rdata);
      end
      @(posedge clk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data, input string name);
      xfer(1'b1, addr, data, 8'h00, 1'b0, 1'b0, name);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
      xfer(1'b0, addr, 8'h00, exp, 1'b0, 1'b1, name);
   endtask

   // Measures the spacing between two consecutive clk_ena ticks.
   task automatic measure_period(input string name, input int exp);
      int a, b;
      a = -1; b = -1;
      for (int i = 0; i < 40 && a < 0; i++) begin @(posedge clk); #1; if (clk_ena) a = cyc; end
      for (int i = 0; i < 40 && b < 0; i++) begin @(posedge clk); #1; if (clk_ena) b = cyc; end
      check(name, (a < 0 || b < 0) ? 32'd0 : 32'(b - a), 32'(exp));
   endtask

   int ld0, ov0, ud0, bo0;

   initial begin
      rst_n = 1'b0; tcnt = 8'h5C; overflow = 1'b0; underflow = 1'b0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;

      // 1. Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1; #1;
      check("reset_outputs",
            {start_counter, load, up_down, enable, clk_ena, clr_overflow, clr_underflow, irq,
             bus.pready, bus.pslverr, bus.prdata}, 32'd0);

      // Table: reset reads, TDR/TCR setup, unmapped and read-only accesses
      vecs.push_back(mkv(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1)); // TDR reset
      vecs.push_back(mkv(1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1)); // TCR reset
      vecs.push_back(mkv(1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1)); // TSR reset
      vecs.push_back(mkv(1'b1, 8'h00, 8'h0A, 8'h00, 1'b0, 1'b0)); // TDR = 0x0A
      vecs.push_back(mkv(1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, 1'b0)); // LOAD|up|en, CKS0
      vecs.push_back(mkv(1'b0, 8'h01, 8'h00, 8'h30, 1'b0, 1'b1)); // LOAD reads 0
      vecs.push_back(mkv(1'b0, 8'h00, 8'h00, 8'h0A, 1'b0, 1'b1));
      vecs.push_back(mkv(1'b0, 8'h03, 8'h00, 8'h5C, 1'b0, 1'b1)); // TCNT
      vecs.push_back(mkv(1'b1, 8'h07, 8'hFF, 8'h00, 1'b1, 1'b0)); // unmapped write
      vecs.push_back(mkv(1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 1'b1)); // unmapped read
      vecs.push_back(mkv(1'b1, 8'h03, 8'h55, 8'h00, 1'b0, 1'b0)); // TCNT write ignored
      vecs.push_back(mkv(1'b0, 8'h00, 8'h00, 8'h0A, 1'b0, 1'b1)); // TDR unchanged
      vecs.push_back(mkv(1'b0, 8'h01, 8'h00, 8'h30, 1'b0, 1'b1)); // TCR unchanged
      vecs.push_back(mkv(1'b0, 8'h03, 8'h00, 8'h5C, 1'b0, 1'b1));
      foreach (vecs[i])
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
              vecs[i].chk_rd, $sformatf("vec%0d", i));

      // 2. Load strobe and CKS=0 tick rate
      check("start_counter", start_counter, 8'h0A);
      check("load_count", load_cnt, 1);
      check("load_fields_new", {ld_ud, ld_en, ld_rdy}, 3'b111);
      measure_period("period_cks0", 2);
      ld0 = load_cnt;
      wr(8'h01, 8'h80, "tcr_load_disabled");
      check("load_when_disabled", load_cnt - ld0, 1);
      check("enable_off", {ld_en, enable}, 2'b00);

      // 3. CKS switching while the counter runs
      wr(8'h01, 8'h33, "tcr_cks3");
      measure_period("period_cks3", 16);
      wr(8'h01, 8'h30, "tcr_cks0");
      measure_period("period_cks0b", 2);
      wr(8'h01, 8'h31, "tcr_cks1");
      measure_period("period_cks1", 4);
      wr(8'h01, 8'h32, "tcr_cks2");
      measure_period("period_cks2", 8);
      for (int i = 0; i < 6; i++) wr(8'h01, 8'h30 | 8'(i % 4), "tcr_cks_mix");

      // 4. Flags, clears, interrupt
      wr(8'h01, 8'h34, "tcr_ovie");
      @(negedge clk); overflow = 1'b1; #1;
      check("irq_ovf", irq, 1'b1);
      rd(8'h02, 8'h01, "tsr_ovf");
      ov0 = clrov_cnt; ud0 = clrud_cnt;
      wr(8'h02, 8'h01, "tsr_clr_ov");
      check("clr_ov_pulses", {8'(clrov_cnt - ov0), 8'(clrud_cnt - ud0)}, 16'h0100);
      @(negedge clk); overflow = 1'b0; #1;
      check("irq_ovf_fall", irq, 1'b0);
      underflow = 1'b1; #1;
      check("irq_udf_masked", irq, 1'b0);
      wr(8'h01, 8'h38, "tcr_udie");
      check("irq_udf", irq, 1'b1);
      rd(8'h02, 8'h02, "tsr_udf");
      ov0 = clrov_cnt; ud0 = clrud_cnt;
      wr(8'h02, 8'h02, "tsr_clr_ud");
      check("clr_ud_pulses", {8'(clrov_cnt - ov0), 8'(clrud_cnt - ud0)}, 16'h0001);
      @(negedge clk); underflow = 1'b0; #1;
      check("irq_udf_fall", irq, 1'b0);
      bo0 = both_cnt;
      wr(8'h02, 8'h03, "tsr_clr_both");
      check("clr_both", both_cnt - bo0, 1);
      check("clr_with_pready", clr_rdy, 1'b1);

      // 6. Reset during WAIT of a TDR write
      wr(8'h00, 8'h00, "tdr_zero");
      ld0 = load_cnt;
      @(posedge clk); #1;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h00; bus.pwdata = 8'hFF;
      @(posedge clk); #1;
      bus.penable = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      check("abort_pready", bus.pready, 1'b0);
      check("abort_tdr", start_counter, 8'h00);
      check("abort_no_load", load_cnt - ld0, 0);
      rd(8'h00, 8'h00, "abort_tdr_rd");
      rd(8'h01, 8'h00, "abort_tcr_rd");

      // Run-wide properties
      check("tick_min_gap_ok", (min_gap >= 2) ? 1 : 0, 1);
      check("pready_one_cycle", max_rdy_run, 1);
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Register-interface controller for the 8-bit timer counter; sits between an APB-style slave bus and the counter.
- Holds the reload value and the control bits, and generates the prescaled clk_ena (divide by 2, 4, 8 or 16).
- Sequences one-cycle load and flag-clear pulses into the counter.
- Reads back the count and flags, and raises a level interrupt.

Parameters:
ADDR_W, 8, bus address width
PSC_W, 4, prescaler counter width; fixes the maximum divide ratio at 2^PSC_W

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
psel  in  1  bus select
penable  in  1  bus access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  register address
pwdata  in  8  write data
prdata  out  8  read data, valid while pready=1
pready  out  1  transfer completion, one cycle per transfer
pslverr  out  1  error for an unmapped address, valid while pready=1
tcnt  in  8  current counter value
overflow  in  1  counter sticky overflow flag
underflow  in  1  counter sticky underflow flag
start_counter  out  8  reload value (TDR)
load  out  1  one-cycle load strobe
up_down  out  1  1 = count up
enable  out  1  count enable
clk_ena  out  1  one-cycle prescaled count tick
clr_overflow  out  1  one-cycle clear strobe
clr_underflow  out  1  one-cycle clear strobe
irq  out  1  interrupt request

Behaviour:
- Register map:
  - 0x00 TDR: RW, reset 0x00.
  - 0x01 TCR: RW. bit7 = LOAD (write-only, always reads 0); bit5 = up_down; bit4 = enable; bit3 = UDIE; bit2 = OVIE; bits1:0 = CKS. Other bits read 0.
  - 0x02 TSR: read {6'b0, underflow, overflow}; write-1-to-clear.
  - 0x03 TCNT: RO; writes ignored, no error.
  - Any other address: pslverr=1 with pready; writes have no effect, prdata=0x00.
- Bus FSM states: IDLE, SETUP, WAIT, DONE.
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> WAIT on psel & penable; back to IDLE if psel drops.
  - WAIT -> DONE unconditionally.
  - DONE -> SETUP if psel & !penable, else IDLE.
- pready, prdata and pslverr are registered and asserted only in DONE: exactly one wait state, so pready rises on the 2nd clock after penable rises.
- Register writes commit on the clock edge entering DONE.
- Reset values: all outputs 0, FSM in IDLE, all registers 0x00, prescaler 0. A reset mid-transfer aborts the transfer with no register update.
- LOAD: a TCR write with bit7=1 makes load=1 for exactly one clk, in the cycle after the commit edge. TCR's other fields update at the commit edge, so up_down and enable are already new while load is high. load is issued even when enable=0.
- TSR write: bit0=1 pulses clr_overflow and bit1=1 pulses clr_underflow, one clk each, same timing as load; both pulse together if both bits are set. Priority between a set and a simultaneous clear belongs to the counter.
- Prescaler: free-running PSC_W-bit up counter, wraps.
  - Each bit k has a registered rising-edge detect.
  - clk_ena = edge-detect of bit CKS: period 2, 4, 8 or 16 clk for CKS = 0..3, high for one clk.
  - Changing CKS never produces a double pulse or a pulse wider than one clk; the first tick under the new CKS is at the next rising edge of the newly selected bit.
- irq = (overflow & OVIE) | (underflow & UDIE). Combinational from registered inputs; level, not pulse.
- Back-to-back transfers: SETUP may follow DONE directly; each transfer takes 3 clk.

Test Plan:
1. Reset: rst_n=0 then released → all outputs 0; reads of TDR, TCR and TSR return 0x00; pready low until the first transfer.
2. Write TDR=0x0A, then TCR=0xB0 (LOAD, up, enable, CKS=0) → start_counter=0x0A; exactly one load pulse; TCR reads back 0x30; clk_ena period 2 clk; pready high for 1 clk per transfer.
3. Write CKS=3 with the counter running → clk_ena period 16 clk, never two pulses within 2 clk across the switch; repeat with CKS 0→1→2.
4. Force overflow=1 with TCR OVIE=1 → irq=1; TSR reads 0x01; write TSR=0x01 → clr_overflow single pulse, clr_underflow stays 0; irq falls when overflow falls. Repeat with underflow, UDIE and TSR=0x02.
5. Access address 0x07 → pslverr=1 with pready; prdata=0x00; no register changes. Write 0x55 to TCNT → no effect, pslverr=0.
6. Assert rst_n=0 during the WAIT state of a TDR write of 0xFF → TDR remains 0x00, FSM returns to IDLE, no load pulse.
